// File: rtl/alu_operand_feeder_pkg.sv
// Shared constants for the ALU operand feeder: default widths, ALU opcodes
// and the issue-FSM state encoding.
package alu_operand_feeder_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 3;
  localparam int REG_N_DEF  = 8;
  localparam int ADDR_W_DEF = 3;

  // ALU opcodes. The feeder never decodes these; they are listed so that
  // the ALU model and any checkers share one definition.
  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Issue FSM encoding. 2'b11 is unused and falls back to IDLE.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_READ = 2'b01;
  localparam state_t ST_EXEC = 2'b10;

  function automatic logic state_is_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/alu_operand_feeder_if.sv
// Bus bundle between the feeder, its instruction source, the preload port,
// the combinational ALU and the writeback consumer.
//
// Handshake: an instruction transfers on a rising clk edge where both
// in_valid and in_ready are 1. The source must hold in_valid and the
// instruction fields stable until that edge; in_ready does not depend on
// in_valid. ld_en, wb_valid are single-cycle strobes with no back-pressure.
interface alu_operand_feeder_if
  import alu_operand_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  // Feeder side
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  ld_en, ld_addr, ld_data,
    input  alu_y,
    output in_ready, alu_op, alu_a, alu_b,
    output wb_valid, wb_addr, wb_data, busy
  );

  // Instruction source / ALU / consumer side
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    output ld_en, ld_addr, ld_data,
    output alu_y,
    input  in_ready, alu_op, alu_a, alu_b,
    input  wb_valid, wb_addr, wb_data, busy
  );

endinterface

// File: rtl/alu_operand_feeder_regfile.sv
// Register file: REG_N x DATA_W, two asynchronous read ports (the caller
// registers the data), one writeback port and one preload port. When both
// target the same entry on the same edge, writeback wins.
module alu_operand_feeder_regfile
  import alu_operand_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_N  = REG_N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data
);

  logic [DATA_W-1:0] r_mem [REG_N];

  // Per-entry write select: writeback has priority over preload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_N; i++) begin
        if (i_wb_en && (i_wb_addr == ADDR_W'(i))) begin
          r_mem[i] <= i_wb_data;
        end else if (i_ld_en && (i_ld_addr == ADDR_W'(i))) begin
          r_mem[i] <= i_ld_data;
        end
      end
    end
  end

  assign o_rd_data_a = r_mem[i_rd_addr_a];
  assign o_rd_data_b = r_mem[i_rd_addr_b];

endmodule

// File: rtl/alu_operand_feeder.sv
// Non-pipelined issue stage for the 8-op ALU: accept an instruction, read
// its operands in READ, hold them to the ALU for a full EXEC cycle, then
// write the ALU result back to rd and pulse wb_valid.
module alu_operand_feeder
  import alu_operand_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int REG_N  = REG_N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_feeder_if.slave  bus,
  output state_t               dbg_state
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_wb_en;

  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;

  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;

  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // in_ready is forced low while reset is asserted, even though the state is IDLE.
  assign w_in_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_wb_en    = (r_state == ST_EXEC);

  // Next-state logic: IDLE -> READ -> EXEC -> IDLE; the spare code recovers to IDLE.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_accept ? ST_READ : ST_IDLE;
      ST_READ: w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction latch, loaded on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
    end else if (w_accept) begin
      r_op  <= bus.in_op;
      r_rd  <= bus.in_rd;
      r_rs1 <= bus.in_rs1;
      r_rs2 <= bus.in_rs2;
    end
  end

  // ALU drive registers: sampled at the end of READ with pre-edge regfile
  // contents, then held through EXEC and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= '0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else if (r_state == ST_READ) begin
      r_alu_op <= r_op;
      r_alu_a  <= w_rd_a;
      r_alu_b  <= w_rd_b;
    end
  end

  // Writeback registers: valid pulses for one cycle, address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_wb_en;
      if (w_wb_en) begin
        r_wb_addr <= r_rd;
        r_wb_data <= bus.alu_y;
      end
    end
  end

  alu_operand_feeder_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_addr_a (r_rs1),
    .i_rd_addr_b (r_rs2),
    .o_rd_data_a (w_rd_a),
    .o_rd_data_b (w_rd_b),
    .i_wb_en     (w_wb_en),
    .i_wb_addr   (r_rd),
    .i_wb_data   (bus.alu_y),
    .i_ld_en     (bus.ld_en),
    .i_ld_addr   (bus.ld_addr),
    .i_ld_data   (bus.ld_data)
  );

  assign bus.in_ready = w_in_ready;
  assign bus.alu_op   = r_alu_op;
  assign bus.alu_a    = r_alu_a;
  assign bus.alu_b    = r_alu_b;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_addr  = r_wb_addr;
  assign bus.wb_data  = r_wb_data;
  assign bus.busy     = state_is_busy(r_state);
  assign dbg_state    = r_state;

endmodule
